// File: rtl/freq_synth.sv
// freq_synth
// ----------
// Rebuilds a 0..999 Hz frequency from a scanned 3-digit BCD display bus and
// drives a square wave of that frequency, derived from the system clock.
//
// A digit is accepted only after STABLE_CYCLES identical {sel,data} samples.
// Each dwell is captured at most once. Capturing the hundreds digit closes a
// frame. The frame is committed, rejected or ignored depending on which
// digits were seen and whether every digit is valid BCD.
//
// The wave comes from a phase accumulator with modulus CLK_HZ. The
// accumulator advances by 2*freq_bin every cycle and wave_out toggles each
// time it wraps, so the toggle rate is 2*freq_bin per second.
//
// Optional feature macro: FREQ_SYNTH_SYNC_EN
//   When defined, scan_sel and scan_data each pass through a 2-flop
//   synchronizer before capture. This adds 2 cycles of capture latency. Use it
//   when the scan bus comes from another clock domain.
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst        in   1   synchronous reset, active-high
//   scan_data  in   4   BCD digit value on the scan bus
//   scan_sel   in   2   digit select: 0 ones, 1 tens, 2 hundreds, 3 idle
//   wave_out   out  1   synthesised square wave
//   freq_bin   out  10  committed frequency in Hz (binary)
//   frame_ok   out  1   one-cycle pulse: new frequency committed
//   frame_err  out  1   one-cycle pulse: complete frame rejected (digit > 9)
module freq_synth #(
    parameter int CLK_HZ        = 50_000_000,
    parameter int STABLE_CYCLES = 4,
    parameter int ACC_W         = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] scan_data,
    input  logic [1:0] scan_sel,
    output logic       wave_out,
    output logic [9:0] freq_bin,
    output logic       frame_ok,
    output logic       frame_err
);

    localparam int               CNT_W   = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    // The count value seen on the cycle whose edge completes the dwell.
    localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(STABLE_CYCLES - 2);
    localparam logic [ACC_W-1:0] ACC_MOD = ACC_W'(CLK_HZ);

    // ------------------------------------------------------------------
    // Input sampling
    // ------------------------------------------------------------------
    logic [1:0] sel_in;
    logic [3:0] data_in;

`ifdef FREQ_SYNTH_SYNC_EN
    logic [1:0] sel_s1_q, sel_s2_q;
    logic [3:0] data_s1_q, data_s2_q;

    // The synchronizer resets to the idle select, so no digit is captured
    // from reset values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_s1_q  <= 2'd3;
            sel_s2_q  <= 2'd3;
            data_s1_q <= 4'd0;
            data_s2_q <= 4'd0;
        end else begin
            sel_s1_q  <= scan_sel;
            sel_s2_q  <= sel_s1_q;
            data_s1_q <= scan_data;
            data_s2_q <= data_s1_q;
        end
    end

    assign sel_in  = sel_s2_q;
    assign data_in = data_s2_q;
`else
    assign sel_in  = scan_sel;
    assign data_in = scan_data;
`endif

    // ------------------------------------------------------------------
    // Dwell detection
    // ------------------------------------------------------------------
    logic [1:0]       sel_prev_q;
    logic [3:0]       data_prev_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             same;
    logic             capture;

    assign same = (sel_in == sel_prev_q) && (data_in == data_prev_q);

    // The count saturates at CNT_MAX, so capture fires only on the edge that
    // moves the count from CNT_ARM to CNT_MAX. A long dwell is captured once.
    always_comb begin
        count_d = '0;
        if (same) begin
            count_d = (count_q == CNT_MAX) ? CNT_MAX : count_q + CNT_W'(1);
        end
    end

    assign capture = same && (count_q == CNT_ARM) && (sel_in != 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_prev_q  <= 2'd3;
            data_prev_q <= 4'd0;
            count_q     <= '0;
        end else begin
            sel_prev_q  <= sel_in;
            data_prev_q <= data_in;
            count_q     <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Digit shadows (0 = ones, 1 = tens, 2 = hundreds)
    // ------------------------------------------------------------------
    logic [3:0] digit_q [0:2];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_shadow
            always_ff @(posedge clk) begin
                if (rst) begin
                    digit_q[gi] <= 4'd0;
                end else if (capture && (sel_in == 2'(gi))) begin
                    digit_q[gi] <= data_in;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Frame evaluation
    // ------------------------------------------------------------------
    logic [1:0] seen_q, seen_d;
    logic       frame_cap;
    logic       digits_ok;
    logic       commit;
    logic       reject;
    logic [9:0] hund10, tens10, ones10;
    logic [9:0] bin_value;

    assign frame_cap = capture && (sel_in == 2'd2);

    // Hundreds is taken straight from the bus. Its shadow is only written
    // on this same edge.
    assign digits_ok = (data_in <= 4'd9) && (digit_q[1] <= 4'd9) && (digit_q[0] <= 4'd9);
    assign commit    = frame_cap && (seen_q == 2'b11) && digits_ok;
    assign reject    = frame_cap && (seen_q == 2'b11) && !digits_ok;

    // 100*H + 10*T + O built from shifts and adds. Valid BCD digits keep
    // the result at 999 or below, so 10 bits are enough.
    assign hund10    = 10'(data_in);
    assign tens10    = 10'(digit_q[1]);
    assign ones10    = 10'(digit_q[0]);
    assign bin_value = (hund10 << 6) + (hund10 << 5) + (hund10 << 2)
                     + (tens10 << 3) + (tens10 << 1) + ones10;

    always_comb begin
        seen_d = seen_q;
        if (capture) begin
            case (sel_in)
                2'd0:    seen_d = seen_q | 2'b01;
                2'd1:    seen_d = seen_q | 2'b10;
                default: seen_d = 2'b00;  // hundreds closes the frame
            endcase
        end
    end

    logic [9:0] freq_q, freq_d;
    logic       frame_ok_q, frame_err_q;

    assign freq_d = commit ? bin_value : freq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            seen_q      <= 2'b00;
            freq_q      <= 10'd0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            seen_q      <= seen_d;
            freq_q      <= freq_d;
            frame_ok_q  <= commit;
            frame_err_q <= reject;
        end
    end

    // ------------------------------------------------------------------
    // Phase-accumulator square-wave generator
    // ------------------------------------------------------------------
    // The generator uses the registered frequency. On the edge where a new
    // frequency is committed, the step still uses the old value. The
    // accumulator is not cleared on a frequency change, so the phase stays
    // continuous.
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] acc_step;
    logic [ACC_W-1:0] acc_nxt;
    logic             acc_wrap;
    logic             wave_q, wave_d;

    assign acc_step = ACC_W'(freq_q) << 1;
    assign acc_nxt  = acc_q + acc_step;
    assign acc_wrap = (acc_nxt >= ACC_MOD);

    always_comb begin
        acc_d  = acc_nxt;
        wave_d = wave_q;
        if (freq_q == 10'd0) begin
            acc_d  = '0;
            wave_d = 1'b0;
        end else if (acc_wrap) begin
            acc_d  = acc_nxt - ACC_MOD;
            wave_d = ~wave_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            wave_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            wave_q <= wave_d;
        end
    end

    assign wave_out  = wave_q;
    assign freq_bin  = freq_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;

endmodule
